digit_argmax: RTL
=================

// Module: digit_argmax
// PURPOSE
//  Reads the NUM_CLASSES layer-2 digit scores after inference completes and selects the predicted digit.
//  Scores are read one per cycle through a select/data interface; the top level muxes digit_output[digit_sel] into digit_value.
//  Produces the predicted index, a one-hot vector for LEDR, the winning score and a confidence flag.
//  The confidence flag is set when the best score beats the second-best by at least MARGIN.
// PARAMETERS
//  NUM_CLASSES  10  number of scores scanned (indices 0..NUM_CLASSES-1)
//  DATA_W       32  signed score width
//  IDX_W        4   width of digit_sel/pred_digit; 2**IDX_W >= NUM_CLASSES
//  MARGIN       0   unsigned minimum (best - second) for confident=1
// PORTS
//  clk          in   1            system clock (MAX10_CLK1_50)
//  rst          in   1            asynchronous, active-high reset
//  start        in   1            pulse: layer 2 finished, scores stable until done
//  digit_sel    out  IDX_W        index of the score requested
//  digit_value  in   DATA_W       signed score for digit_sel presented one cycle earlier
//  busy         out  1            high while scanning
//  done         out  1            one-cycle pulse: result registers updated
//  pred_digit   out  IDX_W        index of the maximum score
//  pred_value   out  DATA_W       maximum score (signed)
//  pred_onehot  out  NUM_CLASSES  1 << pred_digit, 0 until the first result
//  confident    out  1            (pred_value - second best) >= MARGIN
// BEHAVIOUR
//  Reset state: all outputs 0; FSM=IDLE; internal best/second regs = most-negative.
//   rst takes effect at any time; a scan in progress is abandoned with no done.
//  FSM states: IDLE, SCAN, DONE.
//   IDLE -start-> SCAN: digit_sel<=0, cnt<=0, best<=second<=most-negative.
//   SCAN: each edge captures digit_value as score[cnt] and increments cnt and digit_sel.
//   SCAN -> DONE: after the edge that captures score[NUM_CLASSES-1].
//   DONE -> IDLE: unconditional after 1 cycle.
//  Timing: start sampled at edge E0; score[k] is captured at edge E0+k+1.
//   Result registers load and done rises at edge E0+NUM_CLASSES; done is high for one cycle.
//   busy is high from E0 until E0+NUM_CLASSES.
//   digit_sel holds NUM_CLASSES-1 after the last request, then returns to 0 in IDLE.
//  Compare rule, signed:
//   If score > best: second<=best, best<=score, idx<=cnt.
//   Else if score > second: second<=score.
//   Ties never replace best, so the lowest index wins a tie.
//   An equal score becomes second, so a tie gives a difference of 0.
//  Confidence: the difference is computed at DATA_W+1 bits signed; no overflow for any pair.
//   confident = diff >= MARGIN, with MARGIN zero-extended.
//   With MARGIN=0, confident is always 1.
//  pred_* and confident change only at done; they hold their values through the next scan until its done.
//  start while busy (SCAN) is ignored.
//  start in DONE or IDLE is accepted; in DONE the result still posts that cycle.
//  digit_value is don't-care outside SCAN.
// TESTING
//  Scores [5,-3,100,7,0,1,2,3,4,99], MARGIN=0, start pulse:
//   done exactly 10 cycles after the start edge; pred_digit=2, pred_onehot=0x004, pred_value=100, confident=1.
//  Tie, all scores 0 except idx3=idx7=50, MARGIN=1:
//   pred_digit=3, pred_onehot=0x008, confident=0.
//  All negative, all -1000 except idx9=-1, MARGIN=999:
//   pred_digit=9, pred_value=-1, confident=1; with MARGIN=1000, confident=0.
//  Extremes, idx0=32'h7FFFFFFF and all others 32'h80000000, MARGIN=32'hFFFFFFFF:
//   diff=2^32-1, confident=1; pred_digit=0.
//  Reset mid-scan, rst asserted while digit_sel=5:
//   all outputs 0 immediately (async), busy=0, no done.
//   A following start with the first vector gives pred_digit=2.
//  start re-asserted at cycles 3 and 6 of a scan:
//   ignored; exactly one done, at cycle 10. A back-to-back start in the DONE cycle gives a second done 10 cycles later.

Source files
------------

// File: rtl/digit_argmax_if.sv
// Score-scan bus between the argmax block and the surrounding inference top level.
interface digit_argmax_if #(
    parameter int unsigned NUM_CLASSES = 10,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned IDX_W       = 4
);
    logic                     start;
    logic [IDX_W-1:0]         digit_sel;
    logic signed [DATA_W-1:0] digit_value;
    logic                     busy;
    logic                     done;
    logic [IDX_W-1:0]         pred_digit;
    logic signed [DATA_W-1:0] pred_value;
    logic [NUM_CLASSES-1:0]   pred_onehot;
    logic                     confident;

    // Top level / score source side.
    modport master (
        output start,
        output digit_value,
        input  digit_sel,
        input  busy,
        input  done,
        input  pred_digit,
        input  pred_value,
        input  pred_onehot,
        input  confident
    );

    // Argmax engine side.
    modport slave (
        input  start,
        input  digit_value,
        output digit_sel,
        output busy,
        output done,
        output pred_digit,
        output pred_value,
        output pred_onehot,
        output confident
    );
endinterface

// File: rtl/digit_argmax.sv
// Scans NUM_CLASSES signed scores one per cycle and reports the argmax,
// its one-hot form, the winning score and a best-vs-second confidence flag.
module digit_argmax #(
    parameter int unsigned       NUM_CLASSES = 10,
    parameter int unsigned       DATA_W      = 32,
    parameter int unsigned       IDX_W       = 4,
    parameter logic [DATA_W-1:0] MARGIN      = '0
) (
    input  logic         clk,
    input  logic         rst,
    digit_argmax_if.slave bus
);

    localparam logic [IDX_W-1:0]         LAST_IDX = IDX_W'(NUM_CLASSES - 1);
    localparam logic signed [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DONE
    } state_e;

    state_e                   state_q,     state_d;
    logic [IDX_W-1:0]         sel_q,       sel_d;       // doubles as the scan counter
    logic signed [DATA_W-1:0] best_q,      best_d;
    logic signed [DATA_W-1:0] second_q,    second_d;
    logic [IDX_W-1:0]         idx_q,       idx_d;
    logic                     busy_q,      busy_d;
    logic                     done_q,      done_d;
    logic [IDX_W-1:0]         pred_digit_q,  pred_digit_d;
    logic signed [DATA_W-1:0] pred_value_q,  pred_value_d;
    logic [NUM_CLASSES-1:0]   pred_onehot_q, pred_onehot_d;
    logic                     confident_q,   confident_d;

    logic signed [DATA_W-1:0] cand_best;
    logic signed [DATA_W-1:0] cand_second;
    logic [IDX_W-1:0]         cand_idx;
    logic [DATA_W:0]          diff;
    logic [DATA_W+1:0]        slack;
    logic                     cand_conf;

    // Fold the incoming score into best/second; strict compares keep the lowest index on ties.
    always_comb begin
        cand_best   = best_q;
        cand_second = second_q;
        cand_idx    = idx_q;
        if (bus.digit_value > best_q) begin
            cand_second = best_q;
            cand_best   = bus.digit_value;
            cand_idx    = sel_q;
        end else if (bus.digit_value > second_q) begin
            cand_second = bus.digit_value;
        end
        // One extra bit holds any signed difference; a second extra bit holds diff - MARGIN.
        diff      = {cand_best[DATA_W-1], cand_best} - {cand_second[DATA_W-1], cand_second};
        slack     = {diff[DATA_W], diff} - {2'b00, MARGIN};
        cand_conf = ~slack[DATA_W+1];
    end

    // Next-state and next-output logic for the IDLE/SCAN/DONE sequence.
    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        best_d        = best_q;
        second_d      = second_q;
        idx_d         = idx_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        pred_digit_d  = pred_digit_q;
        pred_value_d  = pred_value_q;
        pred_onehot_d = pred_onehot_q;
        confident_d   = confident_q;

        unique case (state_q)
            ST_IDLE: begin
                sel_d = '0;
                if (bus.start) begin
                    state_d  = ST_SCAN;
                    best_d   = MOST_NEG;
                    second_d = MOST_NEG;
                    idx_d    = '0;
                    busy_d   = 1'b1;
                end
            end

            ST_SCAN: begin
                best_d   = cand_best;
                second_d = cand_second;
                idx_d    = cand_idx;
                if (sel_q == LAST_IDX) begin
                    // Last score captured: publish the result this edge.
                    state_d       = ST_DONE;
                    busy_d        = 1'b0;
                    done_d        = 1'b1;
                    pred_digit_d  = cand_idx;
                    pred_value_d  = cand_best;
                    pred_onehot_d = NUM_CLASSES'(1) << cand_idx;
                    confident_d   = cand_conf;
                end else begin
                    sel_d = sel_q + IDX_W'(1);
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                sel_d   = '0;
                if (bus.start) begin
                    state_d  = ST_SCAN;
                    best_d   = MOST_NEG;
                    second_d = MOST_NEG;
                    idx_d    = '0;
                    busy_d   = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                sel_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any scan in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            sel_q         <= '0;
            best_q        <= MOST_NEG;
            second_q      <= MOST_NEG;
            idx_q         <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            pred_digit_q  <= '0;
            pred_value_q  <= '0;
            pred_onehot_q <= '0;
            confident_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            best_q        <= best_d;
            second_q      <= second_d;
            idx_q         <= idx_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            pred_digit_q  <= pred_digit_d;
            pred_value_q  <= pred_value_d;
            pred_onehot_q <= pred_onehot_d;
            confident_q   <= confident_d;
        end
    end

    assign bus.digit_sel   = sel_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.pred_digit  = pred_digit_q;
    assign bus.pred_value  = pred_value_q;
    assign bus.pred_onehot = pred_onehot_q;
    assign bus.confident   = confident_q;

endmodule
